// File: rtl/freq_edge_monitor.sv
// ---------------------------------------------------------------------------
// freq_edge_monitor
//
// Watches a divided clock (clk_in) coming from an upstream divider, measures
// the spacing of its rising edges in clk cycles and declares lock once
// LOCK_COUNT consecutive periods equal EXP_PERIOD. Period mismatches while
// locked and loss of edges (counter saturated at 255) are reported as
// one-cycle error pulses and totalled in a saturating counter.
//
// Parameters
//   EXP_PERIOD    expected clk_in period in clk cycles (2..254)
//   LOCK_COUNT    consecutive matching periods needed for lock (1..15)
//
// Ports
//   clk           system clock, all logic on its rising edge
//   reset         asynchronous, active-high reset
//   clk_in        divided clock under observation (sampled on clk)
//   enable        monitoring enable; low forces IDLE
//   tick          one-cycle pulse per detected clk_in rising edge
//   period        last measured clk_in period (clk cycles)
//   period_valid  one-cycle pulse whenever period is updated
//   locked        high while the monitor is in LOCKED
//   err           one-cycle error pulse (mismatch while locked, or timeout)
//   err_count     saturating error total, cleared only by reset
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | monitoring disabled, waiting for enable
// SYNC    | waiting for the first clk_in rising edge to align the counter
// MEASURE | measuring periods, counting consecutive matches towards lock
// LOCKED  | period stable at EXP_PERIOD; mismatches raise err
// ---------------------------------------------------------------------------
module freq_edge_monitor #(
    parameter int EXP_PERIOD = 4,
    parameter int LOCK_COUNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_in,
    input  logic       enable,
    output logic       tick,
    output logic [7:0] period,
    output logic       period_valid,
    output logic       locked,
    output logic       err,
    output logic [3:0] err_count
);

    localparam logic [7:0] EXP_P   = 8'(EXP_PERIOD);
    localparam logic [3:0] LOCK_C  = 4'(LOCK_COUNT);
    localparam logic [7:0] CNT_MAX = 8'hFF;
    localparam logic [3:0] ERR_MAX = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t     r_state;
    logic       r_prev;
    logic [7:0] r_cnt;
    logic [3:0] r_match;
    logic       r_tick;
    logic [7:0] r_period;
    logic       r_period_valid;
    logic       r_err;
    logic [3:0] r_err_count;

    state_t     w_state_nxt;
    logic [3:0] w_match_nxt;
    logic       w_tick_nxt;
    logic [7:0] w_period_nxt;
    logic       w_period_valid_nxt;
    logic       w_err_nxt;
    logic [3:0] w_err_count_nxt;

    logic       w_rise;
    logic [7:0] w_cnt_nxt;
    logic       w_cnt_hit;
    logic       w_timeout;
    logic [3:0] w_match_inc;
    logic [3:0] w_err_count_inc;

    // Edge detect against the sample taken at the previous clk edge. The
    // sample history is kept even while disabled so that re-enabling does
    // not see a stale level as a fresh edge.
    assign w_rise = clk_in & ~r_prev;

    // Cycles since the last rising edge; reloads to 1 so that the value
    // seen at the next rise equals the period directly.
    assign w_cnt_nxt = w_rise             ? 8'd1  :
                       (r_cnt == CNT_MAX) ? r_cnt :
                                            r_cnt + 8'd1;

    assign w_cnt_hit       = (r_cnt == EXP_P);
    // A rise reloads the counter, so a timeout can only happen without one.
    assign w_timeout       = (r_cnt == CNT_MAX) && !w_rise;
    assign w_match_inc     = r_match + 4'd1;
    assign w_err_count_inc = (r_err_count == ERR_MAX) ? r_err_count
                                                      : r_err_count + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_prev         <= 1'b0;
            r_cnt          <= 8'd0;
            r_match        <= 4'd0;
            r_tick         <= 1'b0;
            r_period       <= 8'd0;
            r_period_valid <= 1'b0;
            r_err          <= 1'b0;
            r_err_count    <= 4'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_prev         <= clk_in;
            r_cnt          <= w_cnt_nxt;
            r_match        <= w_match_nxt;
            r_tick         <= w_tick_nxt;
            r_period       <= w_period_nxt;
            r_period_valid <= w_period_valid_nxt;
            r_err          <= w_err_nxt;
            r_err_count    <= w_err_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_match_nxt        = r_match;
        w_tick_nxt         = 1'b0;
        w_period_nxt       = r_period;
        w_period_valid_nxt = 1'b0;
        w_err_nxt          = 1'b0;
        w_err_count_nxt    = r_err_count;

        if (!enable) begin
            // Disable wins over any edge activity in the same cycle.
            w_state_nxt = IDLE;
            w_match_nxt = 4'd0;
        end else begin
            w_tick_nxt = w_rise && (r_state != IDLE);

            unique case (r_state)
                IDLE: begin
                    w_state_nxt = SYNC;
                end

                SYNC: begin
                    // First edge only aligns the counter; no period yet.
                    if (w_rise) begin
                        w_state_nxt = MEASURE;
                        w_match_nxt = 4'd0;
                    end
                end

                MEASURE: begin
                    if (w_rise) begin
                        w_period_nxt       = r_cnt;
                        w_period_valid_nxt = 1'b1;
                        if (w_cnt_hit) begin
                            w_match_nxt = w_match_inc;
                            if (w_match_inc == LOCK_C) begin
                                w_state_nxt = LOCKED;
                            end
                        end else begin
                            w_match_nxt = 4'd0;
                        end
                    end else if (w_timeout) begin
                        w_err_nxt       = 1'b1;
                        w_err_count_nxt = w_err_count_inc;
                        w_match_nxt     = 4'd0;
                        w_state_nxt     = SYNC;
                    end
                end

                LOCKED: begin
                    if (w_rise) begin
                        w_period_nxt       = r_cnt;
                        w_period_valid_nxt = 1'b1;
                        if (!w_cnt_hit) begin
                            w_err_nxt       = 1'b1;
                            w_err_count_nxt = w_err_count_inc;
                            w_match_nxt     = 4'd0;
                            w_state_nxt     = MEASURE;
                        end
                    end else if (w_timeout) begin
                        w_err_nxt       = 1'b1;
                        w_err_count_nxt = w_err_count_inc;
                        w_match_nxt     = 4'd0;
                        w_state_nxt     = SYNC;
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                    w_match_nxt = 4'd0;
                end
            endcase
        end
    end

    assign tick         = r_tick;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = (r_state == LOCKED);
    assign err          = r_err;
    assign err_count    = r_err_count;

endmodule

// File: tb/tb_freq_edge_monitor.sv
// ---------------------------------------------------------------------------
// tb_freq_edge_monitor
//
// Inputs change on the falling edge of clk. For every driven cycle a
// reference model predicts the outputs after the following rising edge and
// queues them; a separate monitor compares one cycle record per rising edge
// and pops the period / error queues whenever the DUT pulses period_valid or
// err. The model reasons in terms of "cycles since the last clk_in rise" and
// "length of the current run of good periods".
// ---------------------------------------------------------------------------
module tb_freq_edge_monitor;

    localparam int EXP_PERIOD = 4;
    localparam int LOCK_COUNT = 3;

    localparam int PH_IDLE    = 0;
    localparam int PH_SYNC    = 1;
    localparam int PH_MEASURE = 2;
    localparam int PH_LOCKED  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_in;
    logic       enable;
    logic       tick;
    logic [7:0] period;
    logic       period_valid;
    logic       locked;
    logic       err;
    logic [3:0] err_count;

    freq_edge_monitor #(
        .EXP_PERIOD(EXP_PERIOD),
        .LOCK_COUNT(LOCK_COUNT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_in      (clk_in),
        .enable      (enable),
        .tick        (tick),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .err         (err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit tick;
        bit pv;
        bit err;
        bit locked;
        int period;
        int errc;
    } exp_t;

    exp_t q_cyc[$];
    int   q_per[$];
    int   q_err[$];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit m_prev;
    int m_age;     // cycles since last rise, saturating at 255
    int m_phase;
    int m_run;     // consecutive good periods
    int m_period;
    int m_errc;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_prev   = 1'b0;
        m_age    = 0;
        m_phase  = PH_IDLE;
        m_run    = 0;
        m_period = 0;
        m_errc   = 0;
    endtask

    task automatic model_error();
        if (m_errc < 15) m_errc++;
    endtask

    task automatic model_step(input bit en, input bit ci);
        bit   rise;
        exp_t e;
        rise  = ci && !m_prev;
        m_prev = ci;
        e.tick = en && rise && (m_phase != PH_IDLE);
        e.pv   = 1'b0;
        e.err  = 1'b0;
        if (!en) begin
            m_phase = PH_IDLE;
            m_run   = 0;
        end else if (m_phase == PH_IDLE) begin
            m_phase = PH_SYNC;
        end else if (m_phase == PH_SYNC) begin
            if (rise) begin
                m_phase = PH_MEASURE;
                m_run   = 0;
            end
        end else if (rise) begin
            e.pv     = 1'b1;
            m_period = m_age;
            if (m_age == EXP_PERIOD) begin
                if (m_phase == PH_MEASURE) begin
                    m_run++;
                    if (m_run == LOCK_COUNT) m_phase = PH_LOCKED;
                end
            end else begin
                m_run = 0;
                if (m_phase == PH_LOCKED) begin
                    e.err = 1'b1;
                    model_error();
                    m_phase = PH_MEASURE;
                end
            end
        end else if (m_age >= 255) begin
            e.err = 1'b1;
            model_error();
            m_run   = 0;
            m_phase = PH_SYNC;
        end
        m_age    = rise ? 1 : ((m_age < 255) ? m_age + 1 : 255);
        e.locked = (m_phase == PH_LOCKED);
        e.period = m_period;
        e.errc   = m_errc;
        q_cyc.push_back(e);
        if (e.pv)  q_per.push_back(m_period);
        if (e.err) q_err.push_back(m_errc);
    endtask

    task automatic drive_cycle(input bit en, input bit ci);
        @(negedge clk);
        enable = en;
        clk_in = ci;
        model_step(en, ci);
    endtask

    task automatic hold(input bit en, input bit ci, input int n);
        for (int k = 0; k < n; k++) drive_cycle(en, ci);
    endtask

    task automatic periods(input int n, input int hi, input int lo);
        for (int k = 0; k < n; k++) begin
            hold(1'b1, 1'b1, hi);
            hold(1'b1, 1'b0, lo);
        end
    endtask

    task automatic rand_seg(input int n);
        int r;
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 19);
            if (r < 12)      periods(1, 2, 2);
            else if (r < 15) periods(1, 3, 2);
            else if (r < 17) periods(1, $urandom_range(1, 5), $urandom_range(1, 5));
            else if (r < 19) hold(1'b0, clk_in, $urandom_range(1, 4));
            else             hold(1'b1, 1'b0, $urandom_range(250, 262));
        end
    endtask

    // monitor: one cycle record per rising edge, event queues on pulses
    initial begin
        exp_t e;
        int   v;
        forever begin
            @(posedge clk);
            #1;
            if (reset) continue;
            if (q_cyc.size() > 0) begin
                e = q_cyc.pop_front();
                chk("tick",         tick,         e.tick);
                chk("period_valid", period_valid, e.pv);
                chk("err",          err,          e.err);
                chk("locked",       locked,       e.locked);
                chk("period",       period,       e.period);
                chk("err_count",    err_count,    e.errc);
            end
            if (period_valid) begin
                if (q_per.size() == 0) chk("unexpected_period_valid", 1, 0);
                else begin
                    v = q_per.pop_front();
                    chk("period_on_valid", period, v);
                end
            end
            if (err) begin
                if (q_err.size() == 0) chk("unexpected_err", 1, 0);
                else begin
                    v = q_err.pop_front();
                    chk("err_count_on_err", err_count, v);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        clk_in = 1'b0;
        enable = 1'b0;
        model_reset();
        #1;
        chk("rst_tick",      tick,         0);
        chk("rst_period",    period,       0);
        chk("rst_pv",        period_valid, 0);
        chk("rst_locked",    locked,       0);
        chk("rst_err",       err,          0);
        chk("rst_err_count", err_count,    0);
        @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // basic lock with divide-by-4
        drive_cycle(1'b1, 1'b0);
        periods(5, 2, 2);
        chk("locked_after_lock_seq", locked, 1);

        // glitch while locked, then relock
        periods(1, 3, 2);
        periods(5, 2, 2);

        // timeout while locked, then resume
        hold(1'b1, 1'b0, 260);
        periods(6, 2, 2);

        // disable while locked, then re-enable
        hold(1'b0, 1'b0, 3);
        chk("locked_after_disable", locked, 0);
        periods(6, 2, 2);

        // many errors to saturate err_count
        for (int k = 0; k < 18; k++) begin
            periods(4, 2, 2);
            periods(1, 3, 2);
        end
        periods(1, 2, 2);
        chk("err_count_saturated", err_count, 15);

        rand_seg(150);

        // asynchronous reset in the middle of MEASURE
        drive_cycle(1'b1, 1'b0);
        periods(2, 2, 2);
        #2;
        reset = 1'b1;
        q_cyc.delete();
        q_per.delete();
        q_err.delete();
        #1;
        chk("mid_rst_tick",      tick,         0);
        chk("mid_rst_period",    period,       0);
        chk("mid_rst_pv",        period_valid, 0);
        chk("mid_rst_locked",    locked,       0);
        chk("mid_rst_err",       err,          0);
        chk("mid_rst_err_count", err_count,    0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();

        hold(1'b1, 1'b0, 2);
        periods(5, 2, 2);
        rand_seg(60);

        @(posedge clk);
        #3;
        chk("queue_drained", q_cyc.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_edge_monitor.md
FREQ_EDGE_MONITOR -- requirements
Module: freq_edge_monitor

Interface
REQ-001 SHALL have parameter EXP_PERIOD, default 4: expected period of clk_in, in clk cycles (range 2..254).
REQ-002 SHALL have parameter LOCK_COUNT, default 3: number of consecutive matching periods required to lock (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: single rising-edge clock for all logic.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port clk_in, input, 1 bit: divided clock from the upstream divider stage; registered in the clk domain.
REQ-006 SHALL have port enable, input, 1 bit: monitoring enable.
REQ-007 SHALL have port tick, output, 1 bit: one-cycle pulse per detected clk_in rising edge.
REQ-008 SHALL have port period, output, 8 bits: last measured clk_in period, in clk cycles.
REQ-009 SHALL have port period_valid, output, 1 bit: one-cycle pulse when period updates.
REQ-010 SHALL have port locked, output, 1 bit: high while in state LOCKED.
REQ-011 SHALL have port err, output, 1 bit: one-cycle error pulse.
REQ-012 SHALL have port err_count, output, 4 bits: saturating error total.

Function
REQ-013 SHALL hold prev, the clk_in sample from the previous edge; rise SHALL be (clk_in==1 && prev==0) at a clk edge; prev SHALL update on every edge, including when enable=0.
REQ-014 tick SHALL be a register set to 1 for exactly one cycle at each edge where rise is true and state is not IDLE; otherwise tick SHALL be 0.
REQ-015 SHALL keep an 8-bit counter cnt: load 1 on rise; otherwise increment; saturate at 255.
REQ-016 SHALL implement FSM states IDLE, SYNC, MEASURE, LOCKED, plus a 4-bit match counter.
REQ-017 IDLE: on enable=1, go to SYNC at the next edge.
REQ-018 SYNC: on rise, go to MEASURE with match=0; period and period_valid SHALL be unchanged.
REQ-019 MEASURE/LOCKED on rise: period <= cnt and period_valid=1 for one cycle.
REQ-020 MEASURE on rise with cnt==EXP_PERIOD: match increments; on reaching LOCK_COUNT, go to LOCKED in the same edge.
REQ-021 MEASURE on rise with cnt!=EXP_PERIOD: match <= 0; err SHALL NOT pulse.
REQ-022 LOCKED on rise with cnt!=EXP_PERIOD: err=1 for one cycle, err_count increments, match <= 0, go to MEASURE.
REQ-023 Timeout: in MEASURE or LOCKED, when cnt==255 with no rise, err=1 for one cycle, err_count increments, go to SYNC.
REQ-024 Rise and timeout SHALL be mutually exclusive, because rise reloads cnt.
REQ-025 err_count SHALL saturate at 15 and SHALL clear only on reset.
REQ-026 enable=0 in any state SHALL force IDLE at the next edge; match SHALL clear; tick, period_valid, and err SHALL be 0; period and err_count SHALL be retained; enable has priority over rise.
REQ-027 locked SHALL be 1 exactly while the state is LOCKED, and SHALL drop in the cycle the state leaves LOCKED.

Reset
REQ-028 reset=1 SHALL immediately force state=IDLE, prev=0, cnt=0, match=0, tick=0, period=0, period_valid=0, locked=0, err=0, err_count=0.
REQ-029 reset asserted mid-measurement SHALL discard all progress; after release the block SHALL restart from IDLE, and from SYNC once enable=1.

Verification
REQ-030 Lock: clk period 10 ns; clk_in toggles every 2 clk cycles (divide-by-4); enable=1 after reset release -> first tick enters MEASURE; period=4 with period_valid at +4, +8 and +12 cycles; locked=1 at +12; err=0 throughout.
REQ-031 Glitch in lock: once locked, stretch one clk_in high phase to 3 cycles (period 5) -> period=5, err pulse, err_count=1, locked=0, then re-lock after 3 further periods of 4.
REQ-032 Timeout: once locked, hold clk_in=0 -> err pulse 255 cycles after the last rise, state SYNC, locked=0; resume toggling -> re-lock.
REQ-033 Saturation: generate 17 errors -> err_count stays at 15 after the 15th error.
REQ-034 Enable and reset: deassert enable while locked -> IDLE next edge, locked=0, ticks stop, period retained; re-enable -> SYNC. Assert reset mid-MEASURE (asynchronous, between edges) -> all outputs 0 immediately.
